// File: rtl/regfile_scoreboard.sv
// Integer register file (2 async read, 1 sync write, x0 = 0) with a per-register
// pending-write scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int PEND_W = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_out,
    output logic [XLEN-1:0] rs2_out,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            err_unf
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [XLEN-1:0]   regs_q [NREG];
    logic [XLEN-1:0]   regs_d [NREG];
    logic [PEND_W-1:0] cnt_q  [NREG];
    logic [PEND_W-1:0] cnt_d  [NREG];
    logic              err_unf_q;
    logic              err_unf_d;

    logic wr_valid;
    logic iss_fire;
    logic ret_fire;
    logic same_reg;

    // Issue acceptance and retire/underflow qualification all look at the pre-update count.
    always_comb begin
        iss_ready = !iss_en || (iss_rd == '0) || (cnt_q[iss_rd] != CNT_MAX);
        iss_fire  = iss_en && (iss_rd != '0) && (cnt_q[iss_rd] != CNT_MAX);
        wr_valid  = wr_en && (wr_addr != '0);
        ret_fire  = wr_valid && (cnt_q[wr_addr] != '0);
        same_reg  = iss_fire && ret_fire && (iss_rd == wr_addr);
        err_unf_d = wr_valid && (cnt_q[wr_addr] == '0);
    end

    // NOTE: every combinational output takes a default first so no path leaves it unassigned (no latch).
    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (wr_valid) begin
            regs_d[wr_addr] = wr_data;
        end
        if (iss_fire && !same_reg) begin
            cnt_d[iss_rd] = cnt_q[iss_rd] + CNT_ONE;
        end
        if (ret_fire && !same_reg) begin
            cnt_d[wr_addr] = cnt_q[wr_addr] - CNT_ONE;
        end
    end

    // NOTE: the register array is reset too, because software may read it before any write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            regs_q    <= '{default: '0};
            cnt_q     <= '{default: '0};
            err_unf_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            cnt_q     <= cnt_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign err_unf = err_unf_q;

    always_comb begin
        rs1_out  = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
        rs1_busy = (rs1_addr != '0) && (cnt_q[rs1_addr] != '0);
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rs1_addr) && (rs1_addr != '0)) begin
            rs1_out = wr_data;
            if ((cnt_q[rs1_addr] == CNT_ONE) && !(iss_fire && (iss_rd == rs1_addr))) begin
                rs1_busy = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        rs2_out  = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
        rs2_busy = (rs2_addr != '0) && (cnt_q[rs2_addr] != '0);
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rs2_addr) && (rs2_addr != '0)) begin
            rs2_out = wr_data;
            if ((cnt_q[rs2_addr] == CNT_ONE) && !(iss_fire && (iss_rd == rs2_addr))) begin
                rs2_busy = 1'b0;
            end
        end
`endif
    end

endmodule
